// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the memory stage and its responder.
// Signals: Addr/DataIn/Rd/Wr from requester; DataOut/Stall/Done/Err from responder.
// Modports: master (requester side), slave (responder side).
interface dmem_responder_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Stall;
  logic        Done;
  logic        Err;

  modport master (
    output Addr, DataIn, Rd, Wr,
    input  DataOut, Stall, Done, Err
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr,
    output DataOut, Stall, Done, Err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multicycle data-memory responder with a stall/done handshake.
// Accepts one read or write at a time, stalls the requester for LATENCY cycles,
// then completes against an internal array of 2^(ADDR_BITS-1) 16-bit words.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - dmem_responder_if.slave (Addr, DataIn, Rd, Wr in; DataOut, Stall, Done, Err out)
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag accesses with Addr[0]=1 as errors.
module dmem_responder #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W    = ADDR_BITS - 1;
  localparam int unsigned WORDS    = 1 << IDX_W;
  localparam int unsigned CNT_LOAD = (LATENCY >= 2) ? (LATENCY - 2) : 0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic             r_rd, r_wr, r_a0;
  logic [IDX_W-1:0] r_idx;
  logic [15:0]      r_din;
  logic [15:0]      r_dout;
  logic             r_done, r_err;
  logic [15:0]      r_mem [WORDS];

  logic             w_accept, w_complete;
  logic             w_op_rd, w_op_wr, w_op_a0, w_op_err;
  logic [IDX_W-1:0] w_op_idx;
  logic [15:0]      w_op_din;
  logic             w_unused_ok;

  // Next-state logic; the operation completing is taken live from the bus when
  // LATENCY==1 (IDLE goes straight to DONE), otherwise from the latched copies.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_op_rd     = r_rd;
    w_op_wr     = r_wr;
    w_op_a0     = r_a0;
    w_op_idx    = r_idx;
    w_op_din    = r_din;
    case (r_state)
      IDLE: begin
        w_op_rd  = bus.Rd;
        w_op_wr  = bus.Wr;
        w_op_a0  = bus.Addr[0];
        w_op_idx = bus.Addr[ADDR_BITS-1:1];
        w_op_din = bus.DataIn;
        if (bus.Rd | bus.Wr) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_state_nxt = DONE;
            w_complete  = 1'b1;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = 4'(CNT_LOAD);
          end
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = DONE;
          w_complete  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Error condition of the completing operation.
`ifdef DMEM_ALIGN_CHECK_EN
  assign w_op_err = (w_op_rd & w_op_wr) | w_op_a0;
`else
  assign w_op_err = w_op_rd & w_op_wr;
`endif

  // High address bits wrap and are intentionally dropped.
  assign w_unused_ok = ^{bus.Addr, w_op_a0};

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_a0    <= 1'b0;
      r_idx   <= '0;
      r_din   <= 16'd0;
      r_dout  <= 16'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_rd  <= bus.Rd;
        r_wr  <= bus.Wr;
        r_a0  <= bus.Addr[0];
        r_idx <= bus.Addr[ADDR_BITS-1:1];
        r_din <= bus.DataIn;
      end
      r_done <= w_complete;
      r_err  <= w_complete & w_op_err;
      if (w_complete) begin
        r_dout <= (w_op_rd && !w_op_err) ? r_mem[w_op_idx] : 16'd0;
      end
    end
  end

  // Word array; not reset, and no write may land while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && w_complete && w_op_wr && !w_op_err) begin
      r_mem[w_op_idx] <= w_op_din;
    end
  end

  // Stall is combinational and forced low during reset.
  assign bus.Stall   = rst & (((r_state == IDLE) & (bus.Rd | bus.Wr)) | (r_state == BUSY));
  assign bus.DataOut = r_dout;
  assign bus.Done    = r_done;
  assign bus.Err     = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table of full transactions on a
// LATENCY=4 instance plus hand sequences for reset, LATENCY=1 and mid-BUSY reset.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  dmem_responder_if b4();
  dmem_responder_if b1();

  dmem_responder #(.LATENCY(4), .ADDR_BITS(10)) u_dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  dmem_responder #(.LATENCY(1), .ADDR_BITS(10)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        err;
    logic [15:0] dout;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Full transaction on the LATENCY=4 instance, starting just after a rising
  // edge in an IDLE cycle; inputs held while Stall, dropped in the DONE cycle.
  task automatic txn(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    b4.Rd = v.rd; b4.Wr = v.wr; b4.Addr = v.addr; b4.DataIn = v.din;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({tag, "_stall"}, 16'(b4.Stall), 16'd1);
      chk({tag, "_done_lo"}, 16'(b4.Done), 16'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_stall_done"}, 16'(b4.Stall), 16'd0);
    chk({tag, "_done"}, 16'(b4.Done), 16'd1);
    chk({tag, "_err"}, 16'(b4.Err), 16'(v.err));
    chk({tag, "_dout"}, b4.DataOut, v.dout);
    b4.Rd = 1'b0; b4.Wr = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_done_after"}, 16'(b4.Done), 16'd0);
    chk({tag, "_dout_hold"}, b4.DataOut, v.dout);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
    vt[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
    vt[2]  = '{1'b0, 1'b1, 16'h0004, 16'h1234, 1'b0, 16'h0000};
    vt[3]  = '{1'b1, 1'b0, 16'h0404, 16'h0000, 1'b0, 16'h1234};
    vt[4]  = '{1'b0, 1'b1, 16'h0020, 16'hCAFE, 1'b0, 16'h0000};
    vt[5]  = '{1'b1, 1'b1, 16'h0020, 16'h0BAD, 1'b1, 16'h0000};
    vt[6]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hCAFE};
    vt[7]  = '{1'b0, 1'b1, 16'h0010, 16'hA5A5, 1'b0, 16'h0000};
    vt[8]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, ALIGN, ALIGN ? 16'h0000 : 16'hA5A5};
    vt[9]  = '{1'b0, 1'b1, 16'h0030, 16'h1111, 1'b0, 16'h0000};
    vt[10] = '{1'b0, 1'b1, 16'h0031, 16'h2222, ALIGN, 16'h0000};
    vt[11] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, ALIGN ? 16'h1111 : 16'h2222};
    vt[12] = '{1'b0, 1'b1, 16'h07FE, 16'h7777, 1'b0, 16'h0000};
    vt[13] = '{1'b1, 1'b0, 16'h03FE, 16'h0000, 1'b0, 16'h7777};
    vt[14] = '{1'b0, 1'b1, 16'h0030, 16'h1111, 1'b0, 16'h0000};
    vt[15] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hA5A5};

    // Reset with requests pending: Stall forced low, outputs cleared.
    rst = 1'b0;
    b4.Rd = 1'b1; b4.Wr = 1'b0; b4.Addr = 16'h0; b4.DataIn = 16'h0;
    b1.Rd = 1'b0; b1.Wr = 1'b1; b1.Addr = 16'h0; b1.DataIn = 16'h0;
    #3;
    chk("rst_stall4", 16'(b4.Stall), 16'd0);
    chk("rst_stall1", 16'(b1.Stall), 16'd0);
    chk("rst_done", 16'(b4.Done), 16'd0);
    chk("rst_err", 16'(b4.Err), 16'd0);
    chk("rst_dout", b4.DataOut, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    b4.Rd = 1'b0; b1.Wr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_stall", 16'(b4.Stall), 16'd0);
    chk("idle_done", 16'(b4.Done), 16'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) txn(vt[i], i);

    // LATENCY=1: write, then read held high across DONE and into the next IDLE.
    b1.Wr = 1'b1; b1.Addr = 16'h0040; b1.DataIn = 16'h4242;
    @(negedge clk);
    chk("l1w_stall", 16'(b1.Stall), 16'd1);
    chk("l1w_done_lo", 16'(b1.Done), 16'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1w_stall_done", 16'(b1.Stall), 16'd0);
    chk("l1w_done", 16'(b1.Done), 16'd1);
    chk("l1w_err", 16'(b1.Err), 16'd0);
    b1.Wr = 1'b0;
    @(posedge clk); #1;
    b1.Rd = 1'b1;
    @(negedge clk);
    chk("l1r_n_stall", 16'(b1.Stall), 16'd1);
    chk("l1r_n_done", 16'(b1.Done), 16'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1r_n1_stall", 16'(b1.Stall), 16'd0);
    chk("l1r_n1_done", 16'(b1.Done), 16'd1);
    chk("l1r_n1_dout", b1.DataOut, 16'h4242);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1r_n2_stall", 16'(b1.Stall), 16'd1);
    chk("l1r_n2_done", 16'(b1.Done), 16'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1r_n3_done", 16'(b1.Done), 16'd1);
    chk("l1r_n3_dout", b1.DataOut, 16'h4242);
    b1.Rd = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1r_n4_stall", 16'(b1.Stall), 16'd0);
    chk("l1r_n4_done", 16'(b1.Done), 16'd0);
    chk("l1r_n4_hold", b1.DataOut, 16'h4242);
    @(posedge clk); #1;

    // Reset in BUSY of a write: access discarded, array keeps old word.
    b4.Wr = 1'b1; b4.Addr = 16'h0030; b4.DataIn = 16'h5555;
    @(negedge clk);
    chk("rb_stall0", 16'(b4.Stall), 16'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rb_stall1", 16'(b4.Stall), 16'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rb_stall", 16'(b4.Stall), 16'd0);
    chk("rb_done", 16'(b4.Done), 16'd0);
    chk("rb_err", 16'(b4.Err), 16'd0);
    chk("rb_dout", b4.DataOut, 16'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rb_stall_held", 16'(b4.Stall), 16'd0);
    @(posedge clk); #1;
    b4.Wr = 1'b0;
    rst = 1'b1;
    begin
      vec_t v;
      v = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h1111};
      txn(v, 100);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
